// File: rtl/alu_negator_if.sv
// Handshake bundle for the registered negator stage.
// master: drives the operand side and consumes the result.
// slave:  the negator stage itself.
interface alu_negator_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out, ovf, zero
    );

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out, ovf, zero
    );
endinterface

// File: rtl/alu_negator.sv
// Registered two's-complement negator: out = ~in + 1 (mod 2^WIDTH).
// Single pipeline stage with valid/ready on both sides, 1 op/cycle.
// Build option: NEGATOR_FLAGS_EN enables the registered ovf/zero flags;
// without it both flags are tied to 0 and no flag state exists.
module alu_negator #(
    parameter int WIDTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_negator_if.slave  bus
);
    logic             vld_q;
    logic [WIDTH-1:0] res_q;
    logic             accept;

    // Stage is free when empty or when its result leaves this cycle.
    assign bus.in_ready  = !vld_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = vld_q;
    assign bus.out       = res_q;

    // Valid bit: set on accept, cleared on drain without a refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_q <= 1'b0;
        else if (accept)
            vld_q <= 1'b1;
        else if (bus.out_ready)
            vld_q <= 1'b0;
    end

    // Result register: loads only on accept, so idle X on `in` never lands here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            res_q <= '0;
        else if (accept)
            res_q <= ~bus.in + WIDTH'(1);
    end

`ifdef NEGATOR_FLAGS_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic ovf_q;
    logic zero_q;

    // Flags decoded from the operand itself; -x is 0 only for x=0 and equals
    // x only for 0 and the most-negative value, so no adder output is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (accept) begin
            ovf_q  <= (bus.in == MOST_NEG);
            zero_q <= (bus.in == '0);
        end
    end

    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
`else
    assign bus.ovf  = 1'b0;
    assign bus.zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_negator.sv
// Directed bench for alu_negator (WIDTH=64).
// Inputs change 1ns after a rising edge; outputs are sampled at that point too.
module tb_alu_negator;
    localparam int W = 64;
`ifdef NEGATOR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_negator_if #(.WIDTH(W)) bus ();

    alu_negator #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand, check the result one cycle later, then check the drain.
    task automatic do_neg(input string tag, input logic [W-1:0] v, input logic [W-1:0] exp,
                          input logic eovf, input logic ezero);
        bus.in_valid = 1'b1;
        bus.in       = v;
        tick();
        bus.in_valid = 1'b0;
        bus.in       = 'x;
        chk({tag, "_vld"},  {63'd0, bus.out_valid}, 64'd1);
        chk({tag, "_out"},  bus.out, exp);
        chk({tag, "_ovf"},  {63'd0, bus.ovf},  {63'd0, eovf & FLAGS});
        chk({tag, "_zero"}, {63'd0, bus.zero}, {63'd0, ezero & FLAGS});
        tick();
        chk({tag, "_drain_vld"}, {63'd0, bus.out_valid}, 64'd0);
        chk({tag, "_drain_out"}, bus.out, exp);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in        = 'x;
        bus.out_ready = 1'b1;

        // Reset state, no clock edge yet.
        #3;
        chk("rst_vld",   {63'd0, bus.out_valid}, 64'd0);
        chk("rst_out",   bus.out, 64'd0);
        chk("rst_ovf",   {63'd0, bus.ovf},  64'd0);
        chk("rst_zero",  {63'd0, bus.zero}, 64'd0);
        chk("rst_ready", {63'd0, bus.in_ready}, 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_x_vld", {63'd0, bus.out_valid}, 64'd0);
        chk("idle_x_out", bus.out, 64'd0);

        // Arithmetic vectors.
        do_neg("neg0",    64'h0000000000000000, 64'h0000000000000000, 1'b0, 1'b1);
        do_neg("negmin",  64'h8000000000000000, 64'h8000000000000000, 1'b1, 1'b0);
        do_neg("negm1",   64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001, 1'b0, 1'b0);
        do_neg("negAA",   64'hAAAAAAAAAAAAAAAA, 64'h5555555555555556, 1'b0, 1'b0);
        do_neg("neg55",   64'h5555555555555555, 64'hAAAAAAAAAAAAAAAB, 1'b0, 1'b0);
        do_neg("neg1234", 64'h123456789ABCDEF0, 64'hEDCBA98765432110, 1'b0, 1'b0);
        do_neg("neg1",    64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
        do_neg("negmax",  64'h7FFFFFFFFFFFFFFF, 64'h8000000000000001, 1'b0, 1'b0);

        // Back-to-back stream of 1,2,3,4.
        bus.in_valid = 1'b1;
        bus.in = 64'd1; tick();
        chk("s1_out", bus.out, 64'hFFFFFFFFFFFFFFFF);
        bus.in = 64'd2; tick();
        chk("s2_out", bus.out, 64'hFFFFFFFFFFFFFFFE);
        bus.in = 64'd3; tick();
        chk("s3_out", bus.out, 64'hFFFFFFFFFFFFFFFD);
        bus.in = 64'd4; tick();
        chk("s4_out", bus.out, 64'hFFFFFFFFFFFFFFFC);
        chk("s4_vld", {63'd0, bus.out_valid}, 64'd1);

        // Stall three cycles with a new operand pending; it must not be taken.
        bus.in        = 64'd5;
        bus.out_ready = 1'b0;
        #1;
        chk("stall_ready0", {63'd0, bus.in_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall%0d_out", i),   bus.out, 64'hFFFFFFFFFFFFFFFC);
            chk($sformatf("stall%0d_vld", i),   {63'd0, bus.out_valid}, 64'd1);
            chk($sformatf("stall%0d_ready", i), {63'd0, bus.in_ready}, 64'd0);
        end

        // Release: the pending operand 5 is accepted exactly once.
        bus.out_ready = 1'b1;
        tick();
        chk("s5_out", bus.out, 64'hFFFFFFFFFFFFFFFB);
        chk("s5_vld", {63'd0, bus.out_valid}, 64'd1);
        bus.in_valid = 1'b0;
        bus.in       = 'x;
        tick();
        chk("s5_drain_vld", {63'd0, bus.out_valid}, 64'd0);
        chk("s5_drain_out", bus.out, 64'hFFFFFFFFFFFFFFFB);

        // Asynchronous reset while a result is pending.
        bus.in_valid = 1'b1;
        bus.in       = 64'h8000000000000000;
        tick();
        bus.in_valid = 1'b0;
        bus.in       = 'x;
        chk("pre_rst_vld", {63'd0, bus.out_valid}, 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_vld",   {63'd0, bus.out_valid}, 64'd0);
        chk("arst_out",   bus.out, 64'd0);
        chk("arst_ovf",   {63'd0, bus.ovf}, 64'd0);
        chk("arst_ready", {63'd0, bus.in_ready}, 64'd1);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", {63'd0, bus.out_valid}, 64'd0);
        do_neg("post_rst", 64'h0000000000000009, 64'hFFFFFFFFFFFFFFF7, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
